// File: rtl/km_pkg.sv
// Shared constants and state encoding for the modular inverse unit.
package km_pkg;

    localparam int          W = 32;
    localparam logic [W-1:0] Q = 32'd4294967291;   // 2^32 - 5, prime
    localparam logic [W-1:0] E = Q - 32'd2;         // Fermat exponent 32'hFFFF_FFF9

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } km_state_t;

endpackage

// File: rtl/km_rtl.sv
// Combinational Karatsuba modular multiplier: p = (a * b) mod (2^32 - 5).
// Operands are split into 16-bit halves; reduction folds the high word using 2^32 == 5 mod Q.
module km_rtl
    import km_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [15:0] a1, a0, b1, b0;
    logic [16:0] sa, sb;
    logic [31:0] z2, z0;
    logic [33:0] zm, z1;
    logic [63:0] prod;
    logic [34:0] x;
    logic [32:0] y;

    // Karatsuba product followed by two folds of the high part and one conditional subtract
    always_comb begin
        a1   = a[31:16];
        a0   = a[15:0];
        b1   = b[31:16];
        b0   = b[15:0];
        z2   = 32'(a1) * 32'(b1);
        z0   = 32'(a0) * 32'(b0);
        sa   = 17'(a1) + 17'(a0);
        sb   = 17'(b1) + 17'(b0);
        zm   = 34'(sa) * 34'(sb);
        z1   = zm - 34'(z2) - 34'(z0);
        prod = {z2, z0} + (64'(z1) << 16);
        // hi*2^32 + lo == hi*5 + lo (mod Q); second fold leaves y < 2^32 + 40
        x    = 35'(prod[63:32]) * 35'd5 + 35'(prod[31:0]);
        y    = 33'(x[34:32]) * 33'd5 + 33'(x[31:0]);
        p    = (y >= 33'(Q)) ? 32'(y - 33'(Q)) : y[31:0];
    end

endmodule

// File: rtl/km_modinv.sv
// Sequential modular inverse a^(Q-2) mod Q by left-to-right square-and-multiply,
// sharing a single km_rtl multiplier across all 62 compute cycles.
module km_modinv
    import km_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_inv,
    output logic         out_zero
);

    km_state_t    state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] base_q, base_d;
    logic [4:0]   idx_q, idx_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_inv_q, out_inv_d;
    logic         out_zero_q, out_zero_d;

    logic [W-1:0] km_b;
    logic [W-1:0] km_p;

    // Operand B selects base only during multiply steps; A is always the accumulator
    always_comb begin
        km_b = (state_q == MUL) ? base_q : acc_q;
    end

    km_rtl u_km (
        .a (acc_q),
        .b (km_b),
        .p (km_p)
    );

    // Next-state, datapath updates and result capture on the final compute step
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_inv_d   = out_inv_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // in_a < 2Q always, so one conditional subtract fully reduces it
                    base_d  = (in_a >= Q) ? (in_a - Q) : in_a;
                    acc_d   = 32'd1;
                    idx_d   = 5'd31;
                    state_d = SQR;
                end
            end
            SQR: begin
                acc_d = km_p;
                if (E[idx_q]) begin
                    state_d = MUL;
                end else if (idx_q == 5'd0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_inv_d   = (base_q == '0) ? '0 : km_p;
                    out_zero_d  = (base_q == '0);
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            MUL: begin
                acc_d = km_p;
                if (idx_q == 5'd0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_inv_d   = (base_q == '0) ? '0 : km_p;
                    out_zero_d  = (base_q == '0);
                end else begin
                    idx_d   = idx_q - 5'd1;
                    state_d = SQR;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_inv_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_inv_q   <= out_inv_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_inv   = out_inv_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_km_modinv.sv
// Directed self-checking bench for km_modinv.
module tb_km_modinv;

    localparam logic [31:0] QM = 32'd4294967291;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inv;
    logic        out_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    km_modinv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Reference a^(Q-2) mod Q with plain 64-bit arithmetic
    function automatic logic [31:0] powmod(input logic [31:0] a);
        logic [63:0] b, r;
        logic [31:0] e;
        b = {32'd0, a} % {32'd0, QM};
        r = 64'd1;
        e = QM - 32'd2;
        for (int i = 0; i < 32; i++) begin
            if (e[0]) r = (r * b) % {32'd0, QM};
            b = (b * b) % {32'd0, QM};
            e = e >> 1;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] t;
        t = ({32'd0, a} * {32'd0, b}) % {32'd0, QM};
        return t[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents in_a until accepted; timed_out set if in_ready never appears
    task automatic start_op(input logic [31:0] a, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        in_a = a;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) timed_out = 1'b1;
        step();
        in_valid = 1'b0;
        in_a = 32'hDEAD_BEEF;
    endtask

    // Called right after the accept edge; cyc counts edges with the accept edge as 1
    task automatic wait_result(output int cyc, output bit timed_out);
        cyc = 1;
        timed_out = 1'b0;
        while (!out_valid && cyc < 200) begin
            step();
            cyc++;
        end
        if (!out_valid) timed_out = 1'b1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, output logic [31:0] inv, output logic zero,
                          output int cyc, output bit timed_out);
        bit t1, t2;
        start_op(a, t1);
        wait_result(cyc, t2);
        timed_out = t1 | t2;
        inv = out_inv;
        zero = out_zero;
        handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        out_ready = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (out_valid !== 1'b0 || out_inv !== 32'd0 || out_zero !== 1'b0)
            $display("FAIL reset_outputs: valid=%b inv=%0d zero=%b, want 0/0/0", out_valid, out_inv, out_zero);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        // reset and in_valid together: reset wins, nothing accepted
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 32'd7;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_wins: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_one();
        logic [31:0] inv;
        logic zero;
        int cyc;
        bit to;
        run_op(32'd1, inv, zero, cyc, to);
        total_cnt++;
        if (to) $display("FAIL one_timeout: no result within bound");
        else pass_cnt++;
        total_cnt++;
        if (inv !== 32'd1 || zero !== 1'b0) $display("FAIL one_value: inv=%0d zero=%b want 1/0", inv, zero);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 63) $display("FAIL one_latency: got %0d cycles want 63", cyc);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL one_after_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_values();
        logic [31:0] vec_a [3] = '{32'd2, 32'd4294967290, 32'd4294967293};
        logic [31:0] vec_r [3] = '{32'd2147483646, 32'd4294967290, 32'd2147483646};
        logic [31:0] inv;
        logic zero;
        int cyc;
        bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(vec_a[i], inv, zero, cyc, to);
            total_cnt++;
            if (to || inv !== vec_r[i] || zero !== 1'b0)
                $display("FAIL value_%0d: a=%0d inv=%0d zero=%b to=%b want %0d/0", i, vec_a[i], inv, zero, to, vec_r[i]);
            else pass_cnt++;
            total_cnt++;
            if (mulmod(vec_a[i], inv) !== 32'd1)
                $display("FAIL value_prod_%0d: a*inv mod Q=%0d want 1", i, mulmod(vec_a[i], inv));
            else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        logic [31:0] vec_a [2] = '{32'd0, 32'd4294967291};
        logic [31:0] inv;
        logic zero;
        int cyc;
        bit to;
        for (int i = 0; i < 2; i++) begin
            run_op(vec_a[i], inv, zero, cyc, to);
            total_cnt++;
            if (to || inv !== 32'd0 || zero !== 1'b1)
                $display("FAIL zero_%0d: a=%0d inv=%0d zero=%b to=%b want 0/1", i, vec_a[i], inv, zero, to);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] inv0;
        int cyc;
        bit t1, t2;
        int bad;
        start_op(32'd13333, t1);
        wait_result(cyc, t2);
        total_cnt++;
        if (t1 || t2) $display("FAIL stall_timeout: no result within bound");
        else pass_cnt++;
        inv0 = out_inv;
        bad = 0;
        in_valid = 1'b1;
        in_a = 32'd5;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b1 || out_inv !== inv0 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (bad !== 0) $display("FAIL stall_hold: %0d unstable cycles want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (inv0 !== powmod(32'd13333) || mulmod(32'd13333, inv0) !== 32'd1)
            $display("FAIL stall_value: inv=%0d want %0d", inv0, powmod(32'd13333));
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] inv1, inv2;
        int cyc;
        bit to;
        out_ready = 1'b1;
        in_a = 32'd2972;
        in_valid = 1'b1;
        step();
        in_a = 32'd13333;
        wait_result(cyc, to);
        inv1 = out_inv;
        total_cnt++;
        if (to || inv1 !== powmod(32'd2972) || mulmod(32'd2972, inv1) !== 32'd1)
            $display("FAIL b2b_first: inv=%0d to=%b want %0d", inv1, to, powmod(32'd2972));
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: in_ready=%b want 0", in_ready);
        else pass_cnt++;
        wait_result(cyc, to);
        inv2 = out_inv;
        total_cnt++;
        if (to || cyc !== 63 || inv2 !== powmod(32'd13333))
            $display("FAIL b2b_second: inv=%0d cyc=%0d to=%b want %0d/63", inv2, cyc, to, powmod(32'd13333));
        else pass_cnt++;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] inv;
        logic zero;
        int cyc;
        bit to;
        int seen;
        start_op(32'd5, to);
        repeat (29) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        total_cnt++;
        if (seen !== 0 || in_ready !== 1'b1)
            $display("FAIL rst_mid: out_valid high %0d cycles, in_ready=%b want 0/1", seen, in_ready);
        else pass_cnt++;
        run_op(32'd2, inv, zero, cyc, to);
        total_cnt++;
        if (to || inv !== 32'd2147483646 || zero !== 1'b0)
            $display("FAIL rst_mid_next: inv=%0d to=%b want 2147483646", inv, to);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_one();
        test_values();
        test_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
